// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state type and constants for the SPI command arbiter
package spi_arb_pkg;
    localparam int SPI_MOSI_W = 24;
    localparam int SPI_MISO_W = 8;
    localparam logic [SPI_MOSI_W-1:0] AD9517_RD_ID = 24'h008003;
    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT_RISE, WAIT_FALL, ACK} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts one above last grant
//   req_i  : request vector
//   last_i : index of the previous grant
//   gnt_o  : one-hot grant (zero when no request)
//   idx_o  : index of gnt_o
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o
);
    logic [IW-1:0] c;
    // walk from farthest to nearest so the client right after last_i wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        c = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            c = IW'((int'(last_i) + i) % NUM_REQ);
            if (req_i[c]) begin
                gnt_o = '0;
                gnt_o[c] = 1'b1;
                idx_o = c;
            end
        end
    end
endmodule

// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter: shares one SPI master between NUM_REQ cfg clients, round-robin, one transaction per grant
//   i_req_wr/i_req_rd/i_req_data : per-client level requests and instruction words
//   o_req_busy/o_req_ack/o_req_err/o_rd_data : per-client status, completion pulse, error, read result
//   o_spi_wr_cmd/o_spi_rd_cmd/o_spi_wr_data  : strobes and word to the SPI master
//   i_spi_rd_data/i_spi_busy                 : SPI master result and busy
//   SPI_ARB_TIMEOUT_EN: when defined, a busy level held DONE_TO cycles ends the transaction with error
module spi_cmd_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int MOSI_W  = SPI_MOSI_W,
    parameter int MISO_W  = SPI_MISO_W,
    parameter int RISE_TO = 15
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    parameter int DONE_TO = 65535
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_req_wr,
    input  logic [NUM_REQ-1:0]        i_req_rd,
    input  logic [NUM_REQ*MOSI_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_busy,
    output logic [NUM_REQ-1:0]        o_req_ack,
    output logic                      o_req_err,
    output logic [MISO_W-1:0]         o_rd_data,
    output logic                      o_spi_wr_cmd,
    output logic                      o_spi_rd_cmd,
    output logic [MOSI_W-1:0]         o_spi_wr_data,
    input  logic [MISO_W-1:0]         i_spi_rd_data,
    input  logic                      i_spi_busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = 16;
    arb_state_e         state_q;
    logic [NUM_REQ-1:0] gnt, gnt_q, ack_q;
    logic [IW-1:0]      idx, idx_q, ptr_q;
    logic [MOSI_W-1:0]  word, wr_data_q;
    logic [MISO_W-1:0]  rd_data_q;
    logic [CW-1:0]      cnt_q;
    logic               wr_cmd_q, rd_cmd_q, op_wr_q, err_q, sel_wr;
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req_i (i_req_wr | i_req_rd),
        .last_i(ptr_q),
        .gnt_o (gnt),
        .idx_o (idx)
    );
    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_REQ; i++) word = gnt[i] ? i_req_data[i*MOSI_W +: MOSI_W] : word;
    end
    // write wins when a client raises both wr and rd
    assign sel_wr        = |(gnt & i_req_wr);
    assign o_req_busy    = {NUM_REQ{rst || state_q != IDLE || i_spi_busy}};
    assign o_req_ack     = ack_q;
    assign o_req_err     = err_q;
    assign o_rd_data     = rd_data_q;
    assign o_spi_wr_cmd  = wr_cmd_q;
    assign o_spi_rd_cmd  = rd_cmd_q;
    assign o_spi_wr_data = wr_data_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= IW'(NUM_REQ - 1);
            wr_data_q <= '0;
            rd_data_q <= '0;
            cnt_q     <= '0;
            wr_cmd_q  <= 1'b0;
            rd_cmd_q  <= 1'b0;
            op_wr_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_cmd_q <= 1'b0;
            rd_cmd_q <= 1'b0;
            ack_q    <= '0;
            case (state_q)
                IDLE: state_q <= (|(i_req_wr | i_req_rd) && !i_spi_busy) ? ARB : IDLE;
                ARB: begin
                    // a request withdrawn before this cycle simply returns to IDLE
                    if (|gnt) begin
                        gnt_q     <= gnt;
                        idx_q     <= idx;
                        wr_data_q <= word;
                        op_wr_q   <= sel_wr;
                        wr_cmd_q  <= sel_wr;
                        rd_cmd_q  <= !sel_wr;
                        cnt_q     <= '0;
                        state_q   <= ISSUE;
                    end else state_q <= IDLE;
                end
                ISSUE: state_q <= WAIT_RISE;
                WAIT_RISE: begin
                    if (i_spi_busy) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_FALL;
                    end else if (cnt_q == CW'(RISE_TO - 1)) begin
                        err_q   <= 1'b1;
                        ack_q   <= gnt_q;
                        state_q <= ACK;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                WAIT_FALL: begin
                    if (!i_spi_busy) begin
                        rd_data_q <= op_wr_q ? rd_data_q : i_spi_rd_data;
                        ack_q     <= gnt_q;
                        state_q   <= ACK;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(DONE_TO - 1)) begin
                        err_q   <= 1'b1;
                        ack_q   <= gnt_q;
                        state_q <= ACK;
                    end else cnt_q <= cnt_q + 1'b1;
`endif
                end
                ACK: begin
                    err_q   <= 1'b0;
                    ptr_q   <= idx_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
